viterbi_acs_ctrl: RTL and testbench

- Sequencer and path-metric store for the 4-state (K=3) Viterbi ACS datapath.
- Holds the four path-metric registers that feed the combinational ACS unit and accepts one branch-metric step per handshake.
- Normalises metrics to prevent 8-bit overflow and writes the 4-bit decision vectors to survivor memory.
- When a frame finishes, issues a traceback request to the traceback unit.

---
 rtl/viterbi_acs_ctrl.sv | 131 +++++++++++++
 tb/tb_viterbi_acs_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_acs_ctrl.sv
// Sequencer and path-metric store for a 4-state (K=3) Viterbi ACS.
// Ports: clk_i/rst_i; start_i; sym_valid_i/sym_ready_o symbol handshake;
//   pm_sN_new_i/dec_bits_i from ACS; pm_sN_o to ACS; surv_* survivor write;
//   tb_req_o/tb_ack_i traceback handshake; tb_last_addr_o; busy_o; done_o.
module viterbi_acs_ctrl #(
   parameter int         FRAME_LEN = 16,
   parameter logic [7:0] INIT_BIAS = 8'd32
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       start_i,
   input  logic       sym_valid_i,
   output logic       sym_ready_o,
   input  logic [7:0] pm_s0_new_i,
   input  logic [7:0] pm_s1_new_i,
   input  logic [7:0] pm_s2_new_i,
   input  logic [7:0] pm_s3_new_i,
   input  logic [3:0] dec_bits_i,
   output logic [7:0] pm_s0_o,
   output logic [7:0] pm_s1_o,
   output logic [7:0] pm_s2_o,
   output logic [7:0] pm_s3_o,
   output logic       surv_we_o,
   output logic [7:0] surv_addr_o,
   output logic [3:0] surv_data_o,
   output logic       tb_req_o,
   input  logic       tb_ack_i,
   output logic [7:0] tb_last_addr_o,
   output logic       busy_o,
   output logic       done_o
);

   typedef enum logic [2:0] {
      IDLE, RUN, FLUSH, TB_REQ, DONE
   } state_t;

   localparam logic [7:0] LAST = 8'(FRAME_LEN - 1);

   state_t     state_q, state_d;
   logic [7:0] sym_cnt_q, sym_cnt_d;
   logic [7:0] pm_q [4];
   logic [7:0] pm_d [4];
   logic [7:0] pm_n [4];
   logic       surv_we_q, surv_we_d;
   logic [7:0] surv_addr_q, surv_addr_d;
   logic [3:0] surv_data_q, surv_data_d;
   logic       accept;
   logic       norm_hi;

   assign sym_ready_o    = (state_q == RUN);
   assign accept         = sym_valid_i & sym_ready_o;
   assign tb_req_o       = (state_q == TB_REQ);
   assign done_o         = (state_q == DONE);
   assign busy_o         = (state_q != IDLE);
   assign tb_last_addr_o = LAST;

   assign pm_s0_o     = pm_q[0];
   assign pm_s1_o     = pm_q[1];
   assign pm_s2_o     = pm_q[2];
   assign pm_s3_o     = pm_q[3];
   assign surv_we_o   = surv_we_q;
   assign surv_addr_o = surv_addr_q;
   assign surv_data_o = surv_data_q;

   // All metrics at or above 128: subtracting 128 from each keeps the
   // relative ordering and stops the next step from wrapping.
   assign norm_hi = pm_s0_new_i[7] & pm_s1_new_i[7]
                  & pm_s2_new_i[7] & pm_s3_new_i[7];

   always_comb begin
      pm_n[0] = norm_hi ? {1'b0, pm_s0_new_i[6:0]} : pm_s0_new_i;
      pm_n[1] = norm_hi ? {1'b0, pm_s1_new_i[6:0]} : pm_s1_new_i;
      pm_n[2] = norm_hi ? {1'b0, pm_s2_new_i[6:0]} : pm_s2_new_i;
      pm_n[3] = norm_hi ? {1'b0, pm_s3_new_i[6:0]} : pm_s3_new_i;
   end

   always_comb begin
      state_d     = state_q;
      sym_cnt_d   = sym_cnt_q;
      pm_d        = pm_q;
      surv_we_d   = 1'b0;
      surv_addr_d = surv_addr_q;
      surv_data_d = surv_data_q;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               pm_d[0]   = 8'd0;
               pm_d[1]   = INIT_BIAS;
               pm_d[2]   = INIT_BIAS;
               pm_d[3]   = INIT_BIAS;
               sym_cnt_d = 8'd0;
               state_d   = RUN;
            end
         end
         RUN: begin
            if (accept) begin
               pm_d        = pm_n;
               surv_we_d   = 1'b1;
               surv_addr_d = sym_cnt_q;
               surv_data_d = dec_bits_i;
               sym_cnt_d   = sym_cnt_q + 8'd1;
               if (sym_cnt_q == LAST) state_d = FLUSH;
            end
         end
         // One cycle so the final survivor write strobe retires.
         FLUSH:  state_d = TB_REQ;
         TB_REQ: if (tb_ack_i) state_d = DONE;
         DONE:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         sym_cnt_q   <= 8'd0;
         for (int i = 0; i < 4; i++) pm_q[i] <= 8'd0;
         surv_we_q   <= 1'b0;
         surv_addr_q <= 8'd0;
         surv_data_q <= 4'd0;
      end else begin
         state_q     <= state_d;
         sym_cnt_q   <= sym_cnt_d;
         pm_q        <= pm_d;
         surv_we_q   <= surv_we_d;
         surv_addr_q <= surv_addr_d;
         surv_data_q <= surv_data_d;
      end
   end

endmodule

// File: tb/tb_viterbi_acs_ctrl.sv
// Directed testbench for viterbi_acs_ctrl (FRAME_LEN=16, INIT_BIAS=32).
// Drives inputs 1ns after each rising edge and checks registered outputs there.
module tb_viterbi_acs_ctrl;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic       start_i = 1'b0;
   logic       sym_valid_i = 1'b0;
   logic       sym_ready_o;
   logic [7:0] pn0 = 0, pn1 = 0, pn2 = 0, pn3 = 0;
   logic [3:0] dec_bits_i = 0;
   logic [7:0] pm_s0_o, pm_s1_o, pm_s2_o, pm_s3_o;
   logic       surv_we_o;
   logic [7:0] surv_addr_o;
   logic [3:0] surv_data_o;
   logic       tb_req_o;
   logic       tb_ack_i = 1'b0;
   logic [7:0] tb_last_addr_o;
   logic       busy_o;
   logic       done_o;

   int checks = 0;
   int errors = 0;

   viterbi_acs_ctrl #(.FRAME_LEN(16), .INIT_BIAS(8'd32)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
      .sym_valid_i(sym_valid_i), .sym_ready_o(sym_ready_o),
      .pm_s0_new_i(pn0), .pm_s1_new_i(pn1),
      .pm_s2_new_i(pn2), .pm_s3_new_i(pn3),
      .dec_bits_i(dec_bits_i),
      .pm_s0_o(pm_s0_o), .pm_s1_o(pm_s1_o),
      .pm_s2_o(pm_s2_o), .pm_s3_o(pm_s3_o),
      .surv_we_o(surv_we_o), .surv_addr_o(surv_addr_o),
      .surv_data_o(surv_data_o), .tb_req_o(tb_req_o),
      .tb_ack_i(tb_ack_i), .tb_last_addr_o(tb_last_addr_o),
      .busy_o(busy_o), .done_o(done_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic hard_reset();
      rst_i = 1'b1; start_i = 0; sym_valid_i = 0; tb_ack_i = 0;
      step();
      rst_i = 1'b0;
   endtask

   task automatic begin_frame();
      start_i = 1'b1;
      step();
      start_i = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] got;
      step();
      got = {pm_s0_o, pm_s1_o, pm_s2_o, pm_s3_o};
      checks++;
      if (got !== 32'h0) begin
         errors++;
         $display("FAIL reset_pm: got %h want 00000000", got);
      end
      checks++;
      if ({surv_we_o, surv_addr_o, surv_data_o, tb_req_o, done_o,
           busy_o, sym_ready_o} !== 17'h0) begin
         errors++;
         $display("FAIL reset_ctl: we=%b a=%0d d=%h req=%b done=%b busy=%b rdy=%b want all 0",
                  surv_we_o, surv_addr_o, surv_data_o, tb_req_o,
                  done_o, busy_o, sym_ready_o);
      end
      checks++;
      if (tb_last_addr_o !== 8'd15) begin
         errors++;
         $display("FAIL last_addr: got %0d want 15", tb_last_addr_o);
      end
      rst_i = 1'b0;
   endtask

   task automatic test_full_frame();
      logic [3:0] exp_d;
      int         dones;
      begin_frame();
      checks++;
      if ({pm_s0_o, pm_s1_o, pm_s2_o, pm_s3_o} !== {8'd0, 8'd32, 8'd32, 8'd32}) begin
         errors++;
         $display("FAIL init_pm: got %0d %0d %0d %0d want 0 32 32 32",
                  pm_s0_o, pm_s1_o, pm_s2_o, pm_s3_o);
      end
      checks++;
      if (sym_ready_o !== 1'b1 || busy_o !== 1'b1) begin
         errors++;
         $display("FAIL run_flags: rdy=%b busy=%b want 1 1", sym_ready_o, busy_o);
      end
      for (int i = 0; i < 16; i++) begin
         exp_d = (i == 7) ? 4'b1010 : 4'(i + 3);
         sym_valid_i = 1'b1;
         dec_bits_i = exp_d;
         pn0 = 8'(i); pn1 = 8'(i + 10); pn2 = 8'(i + 20); pn3 = 8'(i + 30);
         step();
         checks++;
         if (surv_we_o !== 1'b1 || surv_addr_o !== 8'(i) || surv_data_o !== exp_d) begin
            errors++;
            $display("FAIL frame_write[%0d]: we=%b a=%0d d=%b want 1 %0d %b",
                     i, surv_we_o, surv_addr_o, surv_data_o, i, exp_d);
         end
         checks++;
         if ({pm_s0_o, pm_s3_o} !== {8'(i), 8'(i + 30)}) begin
            errors++;
            $display("FAIL frame_pm[%0d]: got %0d %0d want %0d %0d",
                     i, pm_s0_o, pm_s3_o, i, i + 30);
         end
      end
      sym_valid_i = 1'b0;
      checks++;
      if (tb_req_o !== 1'b0) begin
         errors++;
         $display("FAIL req_early: got %b want 0", tb_req_o);
      end
      step();
      checks++;
      if (tb_req_o !== 1'b1 || surv_we_o !== 1'b0) begin
         errors++;
         $display("FAIL req_rise: req=%b we=%b want 1 0", tb_req_o, surv_we_o);
      end
      step();
      step();
      checks++;
      if (tb_req_o !== 1'b1 || done_o !== 1'b0) begin
         errors++;
         $display("FAIL req_hold: req=%b done=%b want 1 0", tb_req_o, done_o);
      end
      tb_ack_i = 1'b1;
      dones = 0;
      step();
      tb_ack_i = 1'b0;
      if (done_o === 1'b1) dones++;
      checks++;
      if (tb_req_o !== 1'b0 || done_o !== 1'b1 || busy_o !== 1'b1) begin
         errors++;
         $display("FAIL done_cycle: req=%b done=%b busy=%b want 0 1 1",
                  tb_req_o, done_o, busy_o);
      end
      for (int k = 0; k < 3; k++) begin
         step();
         if (done_o === 1'b1) dones++;
      end
      checks++;
      if (dones != 1 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL done_pulse: pulses=%0d busy=%b want 1 0", dones, busy_o);
      end
   endtask

   task automatic test_toggle();
      logic [3:0] pat;
      int         writes;
      logic [7:0] exp_pm;
      pat = 4'b1001;
      writes = 0;
      exp_pm = 8'd0;
      begin_frame();
      for (int k = 0; k < 4; k++) begin
         sym_valid_i = pat[3 - k];
         pn0 = 8'(50 + k); pn1 = 8'd60; pn2 = 8'd61; pn3 = 8'd62;
         dec_bits_i = 4'(k);
         step();
         if (pat[3 - k]) exp_pm = 8'(50 + k);
         checks++;
         if (surv_we_o !== pat[3 - k] ||
             (pat[3 - k] && surv_addr_o !== 8'(writes)) ||
             pm_s0_o !== exp_pm) begin
            errors++;
            $display("FAIL toggle[%0d]: we=%b a=%0d pm0=%0d want %b %0d %0d",
                     k, surv_we_o, surv_addr_o, pm_s0_o, pat[3 - k], writes, exp_pm);
         end
         if (surv_we_o === 1'b1) writes++;
      end
      sym_valid_i = 1'b0;
      checks++;
      if (writes != 2) begin
         errors++;
         $display("FAIL toggle_count: got %0d want 2", writes);
      end
      hard_reset();
   endtask

   task automatic test_reset_mid_run();
      begin_frame();
      sym_valid_i = 1'b1;
      pn0 = 8'd5; pn1 = 8'd6; pn2 = 8'd7; pn3 = 8'd8;
      for (int i = 0; i < 5; i++) step();
      rst_i = 1'b1;
      #1;
      checks++;
      if ({surv_we_o, surv_addr_o, surv_data_o, tb_req_o, done_o, busy_o,
           sym_ready_o, pm_s0_o, pm_s1_o, pm_s2_o, pm_s3_o} !== 49'h0) begin
         errors++;
         $display("FAIL mid_reset: we=%b a=%0d busy=%b rdy=%b pm1=%0d want all 0",
                  surv_we_o, surv_addr_o, busy_o, sym_ready_o, pm_s1_o);
      end
      sym_valid_i = 1'b0;
      step();
      rst_i = 1'b0;
      begin_frame();
      sym_valid_i = 1'b1;
      step();
      sym_valid_i = 1'b0;
      checks++;
      if (surv_we_o !== 1'b1 || surv_addr_o !== 8'd0) begin
         errors++;
         $display("FAIL restart_addr: we=%b a=%0d want 1 0", surv_we_o, surv_addr_o);
      end
      hard_reset();
   endtask

   task automatic test_norm();
      begin_frame();
      sym_valid_i = 1'b1;
      pn0 = 8'd130; pn1 = 8'd129; pn2 = 8'd200; pn3 = 8'd255;
      step();
      checks++;
      if ({pm_s0_o, pm_s1_o, pm_s2_o, pm_s3_o} !== {8'd2, 8'd1, 8'd72, 8'd127}) begin
         errors++;
         $display("FAIL norm_apply: got %0d %0d %0d %0d want 2 1 72 127",
                  pm_s0_o, pm_s1_o, pm_s2_o, pm_s3_o);
      end
      pn1 = 8'd127;
      step();
      sym_valid_i = 1'b0;
      checks++;
      if ({pm_s0_o, pm_s1_o, pm_s2_o, pm_s3_o} !== {8'd130, 8'd127, 8'd200, 8'd255}) begin
         errors++;
         $display("FAIL norm_skip: got %0d %0d %0d %0d want 130 127 200 255",
                  pm_s0_o, pm_s1_o, pm_s2_o, pm_s3_o);
      end
      hard_reset();
   endtask

   task automatic test_ignored();
      begin_frame();
      sym_valid_i = 1'b1;
      pn0 = 8'd11; pn1 = 8'd12; pn2 = 8'd13; pn3 = 8'd14;
      step();
      sym_valid_i = 1'b0;
      start_i = 1'b1;
      pn0 = 8'd99;
      step();
      start_i = 1'b0;
      checks++;
      if (pm_s0_o !== 8'd11 || pm_s1_o !== 8'd12 || busy_o !== 1'b1) begin
         errors++;
         $display("FAIL start_in_run: pm0=%0d pm1=%0d busy=%b want 11 12 1",
                  pm_s0_o, pm_s1_o, busy_o);
      end
      sym_valid_i = 1'b1;
      for (int i = 1; i < 16; i++) begin
         step();
         if (i == 1) begin
            checks++;
            if (surv_addr_o !== 8'd1) begin
               errors++;
               $display("FAIL cnt_after_start: a=%0d want 1", surv_addr_o);
            end
         end
      end
      step();
      step();
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      checks++;
      if (tb_req_o !== 1'b1 || surv_we_o !== 1'b0 || pm_s0_o !== 8'd99) begin
         errors++;
         $display("FAIL tb_req_ignore: req=%b we=%b pm0=%0d want 1 0 99",
                  tb_req_o, surv_we_o, pm_s0_o);
      end
      sym_valid_i = 1'b0;
      tb_ack_i = 1'b1;
      step();
      tb_ack_i = 1'b0;
      step();
      checks++;
      if (busy_o !== 1'b0 || done_o !== 1'b0) begin
         errors++;
         $display("FAIL back_idle: busy=%b done=%b want 0 0", busy_o, done_o);
      end
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_toggle();
      test_reset_mid_run();
      test_norm();
      test_ignored();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
